multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 41 ++++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM and the ALU decoder.
// State codes, opcodes, aluOp and fault codes live here only.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_FAULT     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // States that wait on the memory handshake
  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) ||
           (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles in a wait state.
// expired flags the last tolerated cycle; TIMEOUT_CYCLES=0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (count)
      cnt <= cnt + W'(1);
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = (cnt == W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: state register, memory-wait timeout,
// sticky fault reporting and datapath strobes decoded from state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluOp,
  output logic       pc_source,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] state
);

  state_t st;
  logic   expired;
  logic   clear;

  // Leaving a wait state (ready) or being outside one restarts the count
  assign clear = rst | ~is_wait(st) | mem_ready;
  assign state = st;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .clear  (clear),
    .count  (~mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_FETCH;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      unique case (st)
        S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
          if (mem_ready) begin
            unique case (st)
              S_FETCH:    st <= S_DECODE;
              S_MEM_READ: st <= S_MEM_WB;
              default:    st <= S_FETCH;
            endcase
          end else if (expired) begin
            st         <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_TIMEOUT;
          end
        end
        S_DECODE: begin
          unique case (opcode)
            OP_LOAD, OP_STORE: st <= S_MEM_ADDR;
            OP_RTYPE:          st <= S_EXECUTE;
            OP_BRANCH:         st <= S_BRANCH;
            default: begin
              st         <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_ILLEGAL;
            end
          endcase
        end
        S_MEM_ADDR:
          st <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        S_EXECUTE: st <= S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH: st <= S_FETCH;
        S_FAULT:   st <= S_FAULT;
        default:   st <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    i_or_d        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    aluOp         = ALU_ADD;
    pc_source     = 1'b0;
    instr_done    = 1'b0;
    unique case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluOp     = ALU_FUNCT;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluOp         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
